vga_timing_ctrl: RTL and testbench
==================================

// Module: vga_timing_ctrl
// PURPOSE
//  VGA raster timing generator and output stage. Divides the system clock to a pixel
//  enable and scans the screen. Drives pix_x/pix_y to the pixel-colour generator and
//  samples its combinational 8-bit rgb (R[7:5] G[4:2] B[1:0]) back. Drives the board
//  HS/VS pins and 4-bit DACs, and gives game_logic one frame tick per frame.
// PARAMETERS
//  CLK_DIV   4    system clocks per pixel (100 MHz -> 25 MHz); legal range 1..16
//  H_SYNC    96   hsync pulse width, pixels
//  H_BACK    48   h back porch, pixels
//  H_ACTIVE  640  visible pixels per line
//  H_FRONT   16   h front porch, pixels
//  V_SYNC    2    vsync pulse width, lines
//  V_BACK    33   v back porch, lines
//  V_ACTIVE  480  visible lines
//  V_FRONT   10   v front porch, lines
// PORTS
//  clk          in   1   system clock; the only clock
//  rst_n        in   1   reset, asynchronous, active-low
//  rgb_in       in   8   pixel colour for the current pix_x/pix_y; same-cycle combinational return
//  pix_x        out  10  active column 0..H_ACTIVE-1; 0 outside the active area
//  pix_y        out  9   active row 0..V_ACTIVE-1; 0 outside the active area
//  video_active out  1   current counters are inside the visible area
//  vga_hs       out  1   horizontal sync, active-low, registered
//  vga_vs       out  1   vertical sync, active-low, registered
//  vga_r/g/b    out  4   DAC outputs, registered
//  frame_tick   out  1   one-clk pulse at the start of vertical blanking
// BEHAVIOUR
//  - Timing constants: H_TOTAL = sum of the H_*. V_TOTAL = sum of the V_*.
//    H_START = H_SYNC + H_BACK. V_START = V_SYNC + V_BACK.
//    Line order is sync, back porch, active, front porch.
//  - Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_en = (div_cnt == CLK_DIV-1).
//  - Counters:
//    - h_cnt (10b) advances on pix_en and wraps from H_TOTAL-1 to 0.
//    - v_cnt (10b) advances on pix_en only when h_cnt wraps. It wraps from V_TOTAL-1 to 0.
//    - Both counters hold between pix_en pulses.
//  - Active area:
//    - video_active = (H_START <= h_cnt < H_START+H_ACTIVE) && (V_START <= v_cnt < V_START+V_ACTIVE).
//    - video_active is combinational from the counters.
//    - pix_x = h_cnt - H_START and pix_y = v_cnt - V_START, truncated to the port widths, when active.
//    - Otherwise pix_x = pix_y = 0.
//  - Output register, updated only on pix_en, one pixel of latency, HS/VS/RGB kept mutually aligned:
//    - vga_hs <= !(h_cnt < H_SYNC)
//    - vga_vs <= !(v_cnt < V_SYNC)
//    - When active: vga_r <= {R,R[2]}, vga_g <= {G,G[2]}, vga_b <= {B,B}.
//    - When not active: vga_r/g/b <= 0.
//  - frame_tick = 1 for exactly the clk cycle where pix_en && h_cnt==H_TOTAL-1 &&
//    v_cnt==V_START+V_ACTIVE-1 (end of last visible line). Registered; rises on the next edge.
//  - Reset (asynchronous, any time, including mid-line or mid-frame):
//    - div_cnt=h_cnt=v_cnt=0
//    - vga_hs=vga_vs=1
//    - vga_r/g/b=0
//    - frame_tick=0
//  - After reset release, scanning restarts at (0,0). The first pix_en occurs CLK_DIV clks after release.
//  - CLK_DIV=1: pix_en is tied high.
//  - Each counter's total must fit its 10-bit counter (H_TOTAL and V_TOTAL each <= 1024).
// TESTING  (defaults; 1 pixel = 4 clk, 1 line = 3200 clk, 1 frame = 1,680,000 clk)
//  1. Hold rst_n low for 10 clk, then release.
//     -> hs/vs=1 and rgb=0 during reset.
//     -> vga_hs=0 after the first pix_en, at clk 4.
//     -> Pulling rst_n low mid-frame restores all reset values immediately (asynchronous).
//  2. Run 3 lines.
//     -> vga_hs low for exactly 384 clk.
//     -> hs falling-edge period is 3200 clk.
//     -> video_active high for 2560 clk per visible line.
//  3. Run 2 frames.
//     -> vga_vs low for exactly 6400 clk.
//     -> vs period is 1,680,000 clk.
//     -> hs keeps toggling throughout vsync.
//  4. Check the counter to pixel mapping:
//     -> (h_cnt,v_cnt)=(144,35) gives pix_x=0, pix_y=0, active=1.
//     -> (783,514) gives pix_x=639, pix_y=479.
//     -> (784,514) and (143,35) give active=0 and pix_x=pix_y=0.
//  5. Drive rgb_in=8'b101_010_11 constantly.
//     -> In active area: vga_r=4'b1011, vga_g=4'b0100, vga_b=4'b1111, one pixel after the sample.
//     -> In blanking: vga_r/g/b = 0.
//     -> rgb_in=8'hFF gives 4'hF on all three channels.
//  6. Count frame_tick.
//     -> Exactly one 1-clk pulse per frame.
//     -> It occurs in the cycle after pix_en at (799,514).
//     -> No pulse during the first frame when reset is held past that point.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing generator with pixel-enable divider and registered sync/DAC stage
// ports: clk, rst_n (async, active-low); rgb_in colour returned for pix_x/pix_y;
//        pix_x/pix_y/video_active current scan position; vga_hs/vga_vs active-low syncs;
//        vga_r/g/b 4-bit DAC drive; frame_tick one-clk pulse at start of vertical blanking
module vga_timing_ctrl #(
   parameter int CLK_DIV  = 4,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rgb_in,
   output logic [9:0] pix_x,
   output logic [8:0] pix_y,
   output logic       video_active,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic [3:0] vga_r,
   output logic [3:0] vga_g,
   output logic [3:0] vga_b,
   output logic       frame_tick
);
   localparam logic [3:0]  DIV_LAST   = 4'(CLK_DIV - 1);
   localparam logic [9:0]  H_LAST     = 10'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
   localparam logic [9:0]  V_LAST     = 10'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
   localparam logic [9:0]  H_START    = 10'(H_SYNC + H_BACK);
   localparam logic [9:0]  V_START    = 10'(V_SYNC + V_BACK);
   localparam logic [10:0] H_END      = 11'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [10:0] V_END      = 11'(V_SYNC + V_BACK + V_ACTIVE);
   localparam logic [9:0]  V_VIS_LAST = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
   localparam logic [9:0]  H_SYNC_END = 10'(H_SYNC);
   localparam logic [9:0]  V_SYNC_END = 10'(V_SYNC);
   logic [3:0] div_cnt;
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       pix_en;
   logic       h_wrap;
   logic       v_wrap;
   always_comb begin
      pix_en       = (CLK_DIV == 1) || (div_cnt == DIV_LAST);
      h_wrap       = h_cnt == H_LAST;
      v_wrap       = v_cnt == V_LAST;
      // end bounds compared at 11 bits so a total of exactly 1024 still works
      video_active = h_cnt >= H_START && {1'b0, h_cnt} < H_END &&
                     v_cnt >= V_START && {1'b0, v_cnt} < V_END;
      pix_x        = video_active ? h_cnt - H_START : '0;
      pix_y        = video_active ? 9'(v_cnt - V_START) : '0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt    <= '0;
         h_cnt      <= '0;
         v_cnt      <= '0;
         vga_hs     <= 1'b1;
         vga_vs     <= 1'b1;
         vga_r      <= '0;
         vga_g      <= '0;
         vga_b      <= '0;
         frame_tick <= 1'b0;
      end else begin
         div_cnt    <= pix_en ? '0 : div_cnt + 4'd1;
         frame_tick <= pix_en && h_wrap && v_cnt == V_VIS_LAST;
         if (pix_en) begin
            h_cnt  <= h_wrap ? '0 : h_cnt + 10'd1;
            if (h_wrap)
               v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
            // sync and colour share one register stage so they stay pixel-aligned
            vga_hs <= !(h_cnt < H_SYNC_END);
            vga_vs <= !(v_cnt < V_SYNC_END);
            vga_r  <= video_active ? {rgb_in[7:5], rgb_in[7]} : '0;
            vga_g  <= video_active ? {rgb_in[4:2], rgb_in[4]} : '0;
            vga_b  <= video_active ? {rgb_in[1:0], rgb_in[1:0]} : '0;
         end
      end
   end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: default-timing sync checks plus a small-geometry instance checked against a scan model
module tb_vga_timing_ctrl;
   localparam int D  = 3;
   localparam int HS = 3, HB = 2, HA = 5, HF = 2;
   localparam int VS = 2, VB = 2, VA = 3, VF = 2;
   localparam int HT = HS + HB + HA + HF;
   localparam int VT = VS + VB + VA + VF;
   localparam int FP = HT * VT;
   typedef struct {
      logic [7:0] rgb;
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } vec_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic       rst_a, rst_b;
   logic [7:0] rgb_a, rgb_b;
   logic [9:0] px_a, px_b;
   logic [8:0] py_a, py_b;
   logic       act_a, act_b, hs_a, hs_b, vs_a, vs_b, ft_a, ft_b;
   logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
   vga_timing_ctrl dut_a (
      .clk(clk), .rst_n(rst_a), .rgb_in(rgb_a), .pix_x(px_a), .pix_y(py_a),
      .video_active(act_a), .vga_hs(hs_a), .vga_vs(vs_a), .vga_r(r_a), .vga_g(g_a),
      .vga_b(b_a), .frame_tick(ft_a)
   );
   vga_timing_ctrl #(
      .CLK_DIV(D), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
   ) dut_b (
      .clk(clk), .rst_n(rst_b), .rgb_in(rgb_b), .pix_x(px_b), .pix_y(py_b),
      .video_active(act_b), .vga_hs(hs_b), .vga_vs(vs_b), .vga_r(r_b), .vga_g(g_b),
      .vga_b(b_b), .frame_tick(ft_b)
   );
   int vecs = 0;
   int errs = 0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   function automatic bit in_win(input int h, input int v);
      return h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA;
   endfunction
   // Scan model: after n clocks out of reset, floor(n/D) pixels have been stepped;
   // registered outputs reflect the pixel in view at the most recent step.
   int n = 0, mh, mv, m_cnt = 0;
   int m_r = 0, m_g = 0, m_b = 0;
   bit ma, m_hs = 1, m_vs = 1, m_ft = 0, m_smp_act = 0;
   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         n = 0; m_hs = 1; m_vs = 1; m_r = 0; m_g = 0; m_b = 0; m_ft = 0; m_smp_act = 0;
      end else begin
         if (n % D == D - 1) begin
            mh = ((n / D) % FP) % HT;
            mv = ((n / D) % FP) / HT;
            ma = in_win(mh, mv);
            m_hs = mh >= HS;
            m_vs = mv >= VS;
            m_r = ma ? int'(rgb_b[7:5]) * 2 + int'(rgb_b[7:5]) / 4 : 0;
            m_g = ma ? int'(rgb_b[4:2]) * 2 + int'(rgb_b[4:2]) / 4 : 0;
            m_b = ma ? int'(rgb_b[1:0]) * 5 : 0;
            m_ft = mh == HT - 1 && mv == VS + VB + VA - 1;
            m_smp_act = ma;
            m_cnt++;
         end else
            m_ft = 0;
         n++;
      end
   end
   task automatic check_b();
      int p, h, v;
      bit a;
      p = (n / D) % FP;
      h = p % HT;
      v = p / HT;
      a = in_win(h, v);
      check("b_active", act_b, a);
      check("b_pix_x", px_b, a ? h - HS - HB : 0);
      check("b_pix_y", py_b, a ? v - VS - VB : 0);
      check("b_hs", hs_b, m_hs);
      check("b_vs", vs_b, m_vs);
      check("b_r", r_b, m_r);
      check("b_g", g_b, m_g);
      check("b_b", b_b, m_b);
      check("b_tick", ft_b, m_ft);
   endtask
   vec_t tbl[5];
   initial begin
      int falls[4], rises[4];
      int nf, nr, vs_fall, vs_rise, in_vs, ticks, hi, first, start;
      bit ph, pv, pt, ft_seen, blank_nz, got;
      tbl[0] = '{8'b101_010_11, 4'b1011, 4'b0100, 4'b1111};
      tbl[1] = '{8'hFF, 4'hF, 4'hF, 4'hF};
      tbl[2] = '{8'b011_100_01, 4'b0110, 4'b1001, 4'b0101};
      tbl[3] = '{8'b111_000_10, 4'b1111, 4'b0000, 4'b1010};
      tbl[4] = '{8'b000_111_00, 4'b0000, 4'b1111, 4'b0000};
      rst_a = 0; rst_b = 0; rgb_a = 8'hFF; rgb_b = 8'h00;
      repeat (10) @(negedge clk);
      check("a_rst_hs", hs_a, 1);
      check("a_rst_vs", vs_a, 1);
      check("a_rst_rgb", {r_a, g_a, b_a}, 0);
      check("a_rst_tick", ft_a, 0);
      rst_a = 1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("a_first_hs", hs_a, k < 4);
      end
      check("a_first_vs", vs_a, 0);
      repeat (100) @(negedge clk);
      check("a_pre_async_hs", hs_a, 0);
      @(posedge clk);
      #2 rst_a = 0;
      #1;
      check("a_async_hs", hs_a, 1);
      check("a_async_vs", vs_a, 1);
      check("a_async_x", px_a, 0);
      @(negedge clk);
      rst_a = 1;
      nf = 0; nr = 0; vs_fall = -1; vs_rise = -1; in_vs = 0;
      ph = 1; pv = 1; ft_seen = 0; blank_nz = 0;
      for (int k = 1; k <= 10000; k++) begin
         @(negedge clk);
         if (ph && !hs_a) begin
            if (nf < 4) falls[nf] = k;
            nf++;
            if (!vs_a) in_vs++;
         end
         if (!ph && hs_a) begin
            if (nr < 4) rises[nr] = k;
            nr++;
         end
         if (pv && !vs_a && vs_fall < 0) vs_fall = k;
         if (!pv && vs_a && vs_rise < 0) vs_rise = k;
         ph = hs_a;
         pv = vs_a;
         if (ft_b || ft_a) ft_seen = 1;
         if ({r_a, g_a, b_a} != 0 || act_a) blank_nz = 1;
      end
      check("a_hs_fall_count", nf, 4);
      check("a_hs_first_fall", falls[0], 4);
      check("a_hs_low", rises[0] - falls[0], 384);
      check("a_hs_period", falls[1] - falls[0], 3200);
      check("a_hs_period2", falls[3] - falls[2], 3200);
      check("a_vs_low", vs_rise - vs_fall, 6400);
      check("a_hs_in_vsync", in_vs, 2);
      check("a_blank_rgb", blank_nz, 0);
      check("no_tick_held_reset", ft_seen, 0);
      rst_a = 0;
      rst_b = 1;
      ticks = 0; hi = 0; first = -1; pt = 0;
      for (int k = 1; k <= 3 * FP * D; k++) begin
         @(negedge clk);
         check_b();
         if (ft_b) begin
            hi++;
            if (first < 0) first = k;
            if (!pt) ticks++;
         end
         pt = ft_b;
      end
      check("b_tick_pulses", ticks, 3);
      check("b_tick_cycles", hi, 3);
      check("b_tick_first", first, ((VS + VB + VA - 1) * HT + HT) * D);
      foreach (tbl[i]) begin
         rgb_b = tbl[i].rgb;
         start = m_cnt;
         got = 0;
         for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            got = m_cnt > start && m_smp_act;
         end
         check("tbl_active_seen", got, 1);
         check("tbl_r", r_b, tbl[i].r);
         check("tbl_g", g_b, tbl[i].g);
         check("tbl_b", b_b, tbl[i].b);
         start = m_cnt;
         got = 0;
         for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            got = m_cnt > start && !m_smp_act;
         end
         check("tbl_blank_seen", got, 1);
         check("tbl_blank_rgb", {r_b, g_b, b_b}, 0);
      end
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         check_b();
         rgb_b = 8'($urandom);
         if ($urandom_range(0, 599) == 0) begin
            @(posedge clk);
            #2 rst_b = 0;
            #1;
            check("b_async_hs", hs_b, 1);
            check("b_async_vs", vs_b, 1);
            check("b_async_rgb", {r_b, g_b, b_b}, 0);
            check_b();
            repeat ($urandom_range(1, 5)) @(negedge clk);
            rst_b = 1;
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
